// File: rtl/circuit_test_sequencer.sv
// Self-test sequencer for one combinational CUT: walks every input vector, settles,
// oversamples the synchronized output for oscillation and scores it against a truth table.
//
// state  | meaning
// IDLE   | waiting for start, results cleared
// APPLY  | drive current vector onto cut_in
// SETTLE | wait SETTLE_CYCLES for the CUT to settle
// SAMPLE | take NUM_SAMPLES samples, first is the reference
// EVAL   | score the vector, advance or finish
// DONE   | results held until the next start
module circuit_test_sequencer #(
   parameter int NUM_INPUTS    = 3,
   parameter int SETTLE_CYCLES = 16,
   parameter int NUM_SAMPLES   = 8,
   localparam int V            = 1 << NUM_INPUTS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [V-1:0]          expected,
   output logic [NUM_INPUTS-1:0] cut_in,
   input  logic                  cut_out,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [NUM_INPUTS:0]   match_count,
   output logic [NUM_INPUTS:0]   unstable_count,
   output logic [V-1:0]          fail_mask
);

   localparam int TMAX = (SETTLE_CYCLES > NUM_SAMPLES) ? SETTLE_CYCLES : NUM_SAMPLES;
   localparam int TW   = $clog2(TMAX);

   typedef enum logic [2:0] {
      S_IDLE,
      S_APPLY,
      S_SETTLE,
      S_SAMPLE,
      S_EVAL,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [NUM_INPUTS-1:0] vec_q, vec_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic [NUM_INPUTS-1:0] cut_in_q, cut_in_d;
   logic [V-1:0]          exp_q, exp_d;
   logic                  ref_q, ref_d;
   logic                  diff_q, diff_d;
   logic [NUM_INPUTS:0]   match_q, match_d;
   logic [NUM_INPUTS:0]   unst_q, unst_d;
   logic [V-1:0]          mask_q, mask_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  pass_q, pass_d;
   logic                  sync1_q, sync1_d;
   logic                  sync2_q, sync2_d;

   always_comb begin
      state_d  = state_q;
      vec_d    = vec_q;
      timer_d  = timer_q;
      cut_in_d = cut_in_q;
      exp_d    = exp_q;
      ref_d    = ref_q;
      diff_d   = diff_q;
      match_d  = match_q;
      unst_d   = unst_q;
      mask_d   = mask_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      pass_d   = pass_q;
      sync1_d  = cut_out;
      sync2_d  = sync1_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               exp_d   = expected;
               vec_d   = '0;
               match_d = '0;
               unst_d  = '0;
               mask_d  = '0;
               pass_d  = 1'b0;
               busy_d  = 1'b1;
               state_d = S_APPLY;
            end
         end
         S_APPLY: begin
            cut_in_d = vec_q;
            timer_d  = TW'(SETTLE_CYCLES - 1);
            state_d  = S_SETTLE;
         end
         S_SETTLE: begin
            if (timer_q == '0) begin
               timer_d = TW'(NUM_SAMPLES - 1);
               state_d = S_SAMPLE;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         S_SAMPLE: begin
            // full terminal count means this is the first sample of the window
            if (timer_q == TW'(NUM_SAMPLES - 1)) begin
               ref_d  = sync2_q;
               diff_d = 1'b0;
            end else if (sync2_q != ref_q) begin
               diff_d = 1'b1;
            end
            if (timer_q == '0) begin
               state_d = S_EVAL;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         S_EVAL: begin
            if (diff_q) begin
               unst_d         = unst_q + 1'b1;
               mask_d[vec_q]  = 1'b1;
            end else if (ref_q == exp_q[vec_q]) begin
               match_d = match_q + 1'b1;
            end else begin
               mask_d[vec_q] = 1'b1;
            end
            if (vec_q == NUM_INPUTS'(V - 1)) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               pass_d  = (match_d == (NUM_INPUTS + 1)'(V));
               state_d = S_DONE;
            end else begin
               vec_d   = vec_q + 1'b1;
               state_d = S_APPLY;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         vec_q    <= '0;
         timer_q  <= '0;
         cut_in_q <= '0;
         exp_q    <= '0;
         ref_q    <= 1'b0;
         diff_q   <= 1'b0;
         match_q  <= '0;
         unst_q   <= '0;
         mask_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         vec_q    <= vec_d;
         timer_q  <= timer_d;
         cut_in_q <= cut_in_d;
         exp_q    <= exp_d;
         ref_q    <= ref_d;
         diff_q   <= diff_d;
         match_q  <= match_d;
         unst_q   <= unst_d;
         mask_q   <= mask_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
      end
   end

   assign cut_in         = cut_in_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign match_count    = match_q;
   assign unstable_count = unst_q;
   assign fail_mask      = mask_q;

endmodule
